// File: rtl/mac_dot_accumulator.sv
// mac_dot_accumulator
//   Streams 4-lane signed 8x8 operand beats through a MAC_LAT-stage multiply-add
//   pipeline. It accumulates the 18-bit partial sums over VEC_BEATS beats and
//   emits one signed dot product per vector on a valid/ready output.
//
// Ports
//   clock        in   rising-edge clock
//   resetn       in   asynchronous active-low reset
//   in_valid     in   operand beat valid
//   in_ready     out  beat accepted when in_valid && in_ready
//   in_a, in_b   in   32-bit lanes [8i+7:8i], signed 8-bit, i = 0..3
//   out_valid    out  result valid, held until out_ready
//   out_ready    in   consumer ready
//   out_data     out  ACC_W signed dot product, two's-complement wrap
//   out_overflow out  sticky signed accumulator overflow for this vector
//
// State  | meaning
// -------+----------------------------------------------------------------
// ACCUM  | accepting beats; blocked only while a result waits for the consumer
// DRAIN  | last beat accepted; wait for its result to reach the output register
module mac_dot_accumulator #(
    parameter int VEC_BEATS = 16,
    parameter int MAC_LAT   = 2,
    parameter int ACC_W     = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_overflow
);

    localparam int CNT_W = (VEC_BEATS > 1) ? $clog2(VEC_BEATS) : 1;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               w_accept, w_first, w_last;

    logic [31:0]        r_a, r_b;
    logic [MAC_LAT-1:0] r_vld, r_fst, r_lst;

    logic signed [15:0] w_ext_a [4];
    logic signed [15:0] w_ext_b [4];
    logic signed [15:0] w_prod  [4];
    logic signed [17:0] w_sum0, w_sum_out;

    logic signed [ACC_W-1:0] r_acc, w_sum_ext, w_acc_add;
    logic                    r_ov, w_add_ov, r_fin;

    assign in_ready = (r_state == ST_ACCUM) && !(out_valid && !out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_first  = (r_cnt == '0);
    assign w_last   = (r_cnt == CNT_W'(VEC_BEATS - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_ACCUM;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_ACCUM: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // r_fin high means the output register loads on this edge.
                if (r_fin) w_state_nxt = ST_ACCUM;
            end
            default: w_state_nxt = ST_ACCUM;
        endcase
    end

    // Stage 1 captures the operands; valid/first/last tags ride alongside.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_a   <= '0;
            r_b   <= '0;
            r_vld <= '0;
            r_fst <= '0;
            r_lst <= '0;
        end else begin
            if (w_accept) begin
                r_a <= in_a;
                r_b <= in_b;
            end
            r_vld[0] <= w_accept;
            r_fst[0] <= w_first;
            r_lst[0] <= w_last;
            for (int k = 1; k < MAC_LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_fst[k] <= r_fst[k-1];
                r_lst[k] <= r_lst[k-1];
            end
        end
    end

    // Lanes are sign-extended to 16 bits; every 8x8 signed product fits exactly.
    always_comb begin
        w_sum0 = '0;
        for (int i = 0; i < 4; i++) begin
            w_ext_a[i] = {{8{r_a[8*i+7]}}, r_a[8*i +: 8]};
            w_ext_b[i] = {{8{r_b[8*i+7]}}, r_b[8*i +: 8]};
            w_prod[i]  = w_ext_a[i] * w_ext_b[i];
            w_sum0     = w_sum0 + {{2{w_prod[i][15]}}, w_prod[i]};
        end
    end

    generate
        if (MAC_LAT == 1) begin : g_sum_direct
            assign w_sum_out = w_sum0;
        end else begin : g_sum_pipe
            logic signed [17:0] r_sum [MAC_LAT-1];
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    for (int k = 0; k < MAC_LAT - 1; k++) r_sum[k] <= '0;
                end else begin
                    r_sum[0] <= w_sum0;
                    for (int k = 1; k < MAC_LAT - 1; k++) r_sum[k] <= r_sum[k-1];
                end
            end
            assign w_sum_out = r_sum[MAC_LAT-2];
        end
    endgenerate

    assign w_sum_ext = ACC_W'(w_sum_out);
    assign w_acc_add = r_acc + w_sum_ext;
    assign w_add_ov  = (r_acc[ACC_W-1] == w_sum_ext[ACC_W-1]) &&
                       (w_acc_add[ACC_W-1] != r_acc[ACC_W-1]);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_acc <= '0;
            r_ov  <= 1'b0;
            r_fin <= 1'b0;
        end else begin
            if (r_vld[MAC_LAT-1]) begin
                if (r_fst[MAC_LAT-1]) begin
                    r_acc <= w_sum_ext;
                    r_ov  <= 1'b0;
                end else begin
                    r_acc <= w_acc_add;
                    r_ov  <= r_ov | w_add_ov;
                end
            end
            r_fin <= r_vld[MAC_LAT-1] && r_lst[MAC_LAT-1];
        end
    end

    // A load wins over consumption, so a result arriving while out_ready is high is kept.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_overflow <= 1'b0;
        end else if (r_fin) begin
            out_valid    <= 1'b1;
            out_data     <= r_acc;
            out_overflow <= r_ov;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_dot_accumulator.sv
module tb_mac_dot_accumulator;

    logic        clock = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        rstn [3];
    logic        iv   [3];
    logic [31:0] ia   [3];
    logic [31:0] ib   [3];
    logic        ir   [3];
    logic        ovld [3];
    logic        ordy [3];
    logic        oov  [3];
    logic [31:0] od0, od2;
    logic [19:0] od1;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Instance 0: defaults. Instance 1: ACC_W=20. Instance 2: VEC_BEATS=3.
    mac_dot_accumulator u_dut (
        .clock(clock), .resetn(rstn[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_a(ia[0]), .in_b(ib[0]), .out_valid(ovld[0]), .out_ready(ordy[0]),
        .out_data(od0), .out_overflow(oov[0]));

    mac_dot_accumulator #(.ACC_W(20)) u_dut_w20 (
        .clock(clock), .resetn(rstn[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_a(ia[1]), .in_b(ib[1]), .out_valid(ovld[1]), .out_ready(ordy[1]),
        .out_data(od1), .out_overflow(oov[1]));

    mac_dot_accumulator #(.VEC_BEATS(3)) u_dut_v3 (
        .clock(clock), .resetn(rstn[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_a(ia[2]), .in_b(ib[2]), .out_valid(ovld[2]), .out_ready(ordy[2]),
        .out_data(od2), .out_overflow(oov[2]));

    function automatic logic [31:0] od_of(input int idx);
        case (idx)
            0:       od_of = od0;
            1:       od_of = {12'b0, od1};
            default: od_of = od2;
        endcase
    endfunction

    function automatic int dot4(input logic [31:0] a, input logic [31:0] b);
        int  s;
        byte sa, sb;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            sa = a[8*i +: 8];
            sb = b[8*i +: 8];
            s  = s + int'(sa) * int'(sb);
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input int idx, input logic [31:0] a, input logic [31:0] b,
                             output int acc_cyc);
        bit ok;
        ok = 0;
        acc_cyc = 0;
        @(negedge clock);
        iv[idx] = 1'b1;
        ia[idx] = a;
        ib[idx] = b;
        for (int n = 0; n < 200; n++) begin
            if (ir[idx]) begin
                @(posedge clock);
                #1;
                acc_cyc = cyc;
                ok = 1;
                break;
            end
            @(negedge clock);
        end
        iv[idx] = 1'b0;
        if (!ok) check("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic send_vec(input int idx, input int nbeats, input logic [31:0] a,
                            input logic [31:0] b, output int last_cyc);
        for (int k = 0; k < nbeats; k++) send_beat(idx, a, b, last_cyc);
    endtask

    task automatic wait_result(input int idx, input string tag, input logic [31:0] exp,
                               input logic exp_ov, output int vcyc);
        bit got;
        got = 0;
        vcyc = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clock);
            if (ovld[idx]) begin
                got = 1;
                vcyc = cyc;
                break;
            end
        end
        check({tag, "_valid"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, "_data"}, od_of(idx), exp);
            check({tag, "_ovf"}, 32'(oov[idx]), 32'(exp_ov));
            if (ordy[idx]) begin
                @(negedge clock);
                check({tag, "_consumed"}, 32'(ovld[idx]), 32'd0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t_acc, t_val, gaps, nvec;
        int          exp_i;
        logic [31:0] ra, rb;
        bit          stable;

        for (int i = 0; i < 3; i++) begin
            rstn[i] = 1'b0; iv[i] = 1'b0; ia[i] = '0; ib[i] = '0; ordy[i] = 1'b1;
        end
        repeat (3) @(negedge clock);
        #1;
        check("rst_out_valid", 32'(ovld[0]), 32'd0);
        check("rst_out_data", od0, 32'd0);
        check("rst_out_ovf", 32'(oov[0]), 32'd0);
        @(negedge clock);
        for (int i = 0; i < 3; i++) rstn[i] = 1'b1;
        #1;
        check("rst_in_ready", 32'(ir[0]), 32'd1);

        // Unit lanes: 16 beats * 4 lanes -> 64, result MAC_LAT+1 cycles after last accept.
        send_vec(0, 16, 32'h01010101, 32'h01010101, t_acc);
        wait_result(0, "t1", 32'd64, 1'b0, t_val);
        check("t1_latency", 32'(t_val - t_acc), 32'd3);

        // Extreme lanes.
        send_vec(0, 16, 32'h80808080, 32'h80808080, t_acc);
        wait_result(0, "t2a", 32'h00100000, 1'b0, t_val);
        send_vec(0, 16, 32'h7F7F7F7F, 32'h80808080, t_acc);
        wait_result(0, "t2b", 32'hFFF02000, 1'b0, t_val);

        // Stalled consumer: first result must hold and gate the next vector.
        ordy[0] = 1'b0;
        send_vec(0, 16, 32'h01010101, 32'h01010101, t_acc);
        wait_result(0, "t4a", 32'd64, 1'b0, t_val);
        iv[0] = 1'b1; ia[0] = 32'h02020202; ib[0] = 32'h01010101;
        stable = 1;
        repeat (4) begin
            @(negedge clock);
            if (od0 !== 32'd64 || ovld[0] !== 1'b1 || ir[0] !== 1'b0) stable = 0;
        end
        check("t4_hold_stable", 32'(stable), 32'd1);
        check("t4_in_ready_low", 32'(ir[0]), 32'd0);
        ordy[0] = 1'b1;
        #1;
        check("t4_in_ready_release", 32'(ir[0]), 32'd1);
        @(posedge clock);
        #1;
        iv[0] = 1'b0;
        @(negedge clock);
        check("t4_first_consumed", 32'(ovld[0]), 32'd0);
        send_vec(0, 15, 32'h02020202, 32'h01010101, t_acc);
        wait_result(0, "t4b", 32'd128, 1'b0, t_val);

        // Mid-vector reset: outputs clear asynchronously, partial sum discarded.
        send_vec(0, 7, 32'h05050505, 32'h03030303, t_acc);
        @(negedge clock);
        rstn[0] = 1'b0;
        #1;
        check("t6_rst_data", od0, 32'd0);
        check("t6_rst_valid", 32'(ovld[0]), 32'd0);
        check("t6_rst_ovf", 32'(oov[0]), 32'd0);
        @(negedge clock);
        rstn[0] = 1'b1;
        #1;
        check("t6_in_ready", 32'(ir[0]), 32'd1);
        send_vec(0, 16, 32'h01010101, 32'h01010101, t_acc);
        wait_result(0, "t6", 32'd64, 1'b0, t_val);

        // ACC_W=20: 16 * 65536 wraps to 0 with overflow; next vector clears the flag.
        send_vec(1, 16, 32'h80808080, 32'h80808080, t_acc);
        wait_result(1, "t3a", 32'd0, 1'b1, t_val);
        send_vec(1, 16, 32'h01010101, 32'h01010101, t_acc);
        wait_result(1, "t3b", 32'd64, 1'b0, t_val);

        // VEC_BEATS=3 with random gaps and random signed lanes.
        nvec = 4;
        for (int v = 0; v < nvec; v++) begin
            exp_i = 0;
            for (int k = 0; k < 3; k++) begin
                gaps = $urandom_range(0, 2);
                repeat (gaps) @(negedge clock);
                ra = $urandom;
                rb = $urandom;
                exp_i = exp_i + dot4(ra, rb);
                send_beat(2, ra, rb, t_acc);
            end
            wait_result(2, "t5", 32'(exp_i), 1'b0, t_val);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
